// File: rtl/pht_sat_table_pkg.sv
// ============================================================================
// Module      : pht_pkg
// Description : Shared types and saturating-counter helpers for pht_sat_table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pht_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } pht_state_e;

    // Weakly not-taken: 2^(ctr_w-1) - 1.
    function automatic logic [3:0] pht_init(input int ctr_w);
        return 4'((1 << (ctr_w - 1)) - 1);
    endfunction

    function automatic logic [3:0] pht_sat_next(input logic [3:0] ctr,
                                                input logic       taken,
                                                input int         ctr_w);
        logic [3:0] sat_max;
        sat_max = 4'((1 << ctr_w) - 1);
        if (taken) begin
            return (ctr == sat_max) ? ctr : ctr + 4'd1;
        end
        return (ctr == 4'd0) ? ctr : ctr - 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pht_sat_table_if.sv
// ============================================================================
// Module      : pht_sat_table_if
// Description : Lookup / update / flush signal bundle for pht_sat_table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pht_sat_table_if #(
    parameter int IDX_W = 4,
    parameter int CTR_W = 2
);
    logic             pred_valid_i;
    logic [IDX_W-1:0] pred_idx_i;
    logic             pred_valid_o;
    logic             pred_taken_o;
    logic [CTR_W-1:0] pred_ctr_o;
    logic             upd_valid_i;
    logic [IDX_W-1:0] upd_idx_i;
    logic             upd_taken_i;
    logic             flush_i;
    logic             busy_o;

    modport slave (
        input  pred_valid_i, pred_idx_i, upd_valid_i, upd_idx_i, upd_taken_i, flush_i,
        output pred_valid_o, pred_taken_o, pred_ctr_o, busy_o
    );

    modport master (
        output pred_valid_i, pred_idx_i, upd_valid_i, upd_idx_i, upd_taken_i, flush_i,
        input  pred_valid_o, pred_taken_o, pred_ctr_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/pht_sat_ctr.sv
// ============================================================================
// Module      : pht_sat_ctr
// Description : One saturating counter; load-INIT has priority over update.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pht_sat_ctr
    import pht_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             we_i,
    input  wire logic             load_init_i,
    input  wire logic             taken_i,
    output logic      [CTR_W-1:0] ctr_o
);

    localparam logic [CTR_W-1:0] INIT = CTR_W'(pht_init(CTR_W));

    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (load_init_i) begin
            ctr_d = INIT;
        end else if (we_i) begin
            ctr_d = CTR_W'(pht_sat_next(4'(ctr_q), taken_i, CTR_W));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctr_q <= INIT;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_o = ctr_q;

endmodule

`default_nettype wire

// File: rtl/pht_sat_table.sv
// ============================================================================
// Module      : pht_sat_table
// Description : Pattern history table of saturating counters with registered
//               lookup, update port and sequenced flush. Optional macro
//               PHT_BYPASS_EN forwards a same-cycle update to the lookup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pht_sat_table
    import pht_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input wire logic        clk,
    input wire logic        reset,
    pht_sat_table_if.slave  bus
);

    localparam int               IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] INIT  = CTR_W'(pht_init(CTR_W));
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(ENTRIES - 1);

    pht_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             pred_valid_q, pred_valid_d;
    logic [CTR_W-1:0] pred_ctr_q, pred_ctr_d;

    logic             flushing;
    logic             upd_accept;
    logic [CTR_W-1:0] ctr_arr [ENTRIES];
    logic [CTR_W-1:0] rd_raw;
    logic [CTR_W-1:0] lookup_val;

    assign flushing   = (state_q == ST_FLUSH);
    assign upd_accept = bus.upd_valid_i && (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.flush_i) begin
                    state_d = ST_FLUSH;
                    ptr_d   = '0;
                end
            end
            ST_FLUSH: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        pht_sat_ctr #(
            .CTR_W (CTR_W)
        ) u_ctr (
            .clk         (clk),
            .reset       (reset),
            .we_i        (upd_accept && (bus.upd_idx_i == IDX_W'(i))),
            .load_init_i (flushing && (ptr_q == IDX_W'(i))),
            .taken_i     (bus.upd_taken_i),
            .ctr_o       (ctr_arr[i])
        );
    end

    assign rd_raw = ctr_arr[bus.pred_idx_i];

`ifdef PHT_BYPASS_EN
    logic [CTR_W-1:0] rd_fwd;
    assign rd_fwd = CTR_W'(pht_sat_next(4'(rd_raw), bus.upd_taken_i, CTR_W));

    always_comb begin
        lookup_val = rd_raw;
        if (upd_accept && (bus.upd_idx_i == bus.pred_idx_i)) begin
            lookup_val = rd_fwd;
        end
        if (flushing) begin
            lookup_val = INIT;
        end
    end
`else
    // Same-cycle update is not forwarded; the stored value is returned.
    always_comb begin
        lookup_val = rd_raw;
        if (flushing) begin
            lookup_val = INIT;
        end
    end
`endif

    always_comb begin
        pred_valid_d = bus.pred_valid_i;
        pred_ctr_d   = pred_ctr_q;
        if (bus.pred_valid_i) begin
            pred_ctr_d = lookup_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_valid_q <= 1'b0;
            pred_ctr_q   <= '0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_ctr_q   <= pred_ctr_d;
        end
    end

    assign bus.pred_valid_o = pred_valid_q;
    assign bus.pred_ctr_o   = pred_ctr_q;
    assign bus.pred_taken_o = pred_ctr_q[CTR_W-1];
    assign bus.busy_o       = flushing;

endmodule

`default_nettype wire

// File: tb/tb_pht_sat_table.sv
// ============================================================================
// Module      : tb_pht_sat_table
// Description : Scoreboard bench for pht_sat_table (16 x 2-bit default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pht_sat_table;

    logic clk;
    logic reset;

    int n_cmp;
    int n_err;

    logic [1:0] exp_q [$];

    pht_sat_table_if #(.IDX_W(4), .CTR_W(2)) bus ();

    pht_sat_table #(
        .ENTRIES (16),
        .CTR_W   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected value per returned lookup.
    always @(negedge clk) begin
        if (!reset && bus.pred_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pred_valid", 1, 0);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                chk("pred_ctr", int'(bus.pred_ctr_o), int'(e));
                chk("pred_taken", int'(bus.pred_taken_o), int'(e[1]));
            end
        end
    end

    task automatic clear_inputs();
        bus.pred_valid_i = 1'b0;
        bus.pred_idx_i   = '0;
        bus.upd_valid_i  = 1'b0;
        bus.upd_idx_i    = '0;
        bus.upd_taken_i  = 1'b0;
        bus.flush_i      = 1'b0;
    endtask

    task automatic step(input logic pv, input logic [3:0] pidx,
                        input logic uv, input logic [3:0] uidx, input logic ut,
                        input logic fl, input logic [1:0] exp);
        bus.pred_valid_i = pv;
        bus.pred_idx_i   = pidx;
        bus.upd_valid_i  = uv;
        bus.upd_idx_i    = uidx;
        bus.upd_taken_i  = ut;
        bus.flush_i      = fl;
        if (pv) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic lookup(input logic [3:0] idx, input logic [1:0] exp);
        step(1'b1, idx, 1'b0, 4'd0, 1'b0, 1'b0, exp);
    endtask

    task automatic update(input logic [3:0] idx, input logic taken);
        step(1'b0, 4'd0, 1'b1, idx, taken, 1'b0, 2'd0);
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] same_cycle_exp;
        n_cmp = 0;
        n_err = 0;
        clear_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pred_valid", int'(bus.pred_valid_o), 0);
        chk("rst_pred_ctr", int'(bus.pred_ctr_o), 0);
        chk("rst_pred_taken", int'(bus.pred_taken_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) lookup(4'(i), 2'b01);

        // Taken saturation on idx 5
        update(4'd5, 1'b1); lookup(4'd5, 2'b10);
        update(4'd5, 1'b1); lookup(4'd5, 2'b11);
        update(4'd5, 1'b1); lookup(4'd5, 2'b11);

        // Not-taken saturation on idx 9
        update(4'd9, 1'b0); lookup(4'd9, 2'b00);
        update(4'd9, 1'b0); lookup(4'd9, 2'b00);
        update(4'd9, 1'b0); lookup(4'd9, 2'b00);

        // Same-cycle update and lookup of idx 3 (stored 01)
`ifdef PHT_BYPASS_EN
        same_cycle_exp = 2'b10;
`else
        same_cycle_exp = 2'b01;
`endif
        step(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b0, same_cycle_exp);
        lookup(4'd3, 2'b10);
        idle();
        chk("hold_pred_valid", int'(bus.pred_valid_o), 0);
        chk("hold_pred_ctr", int'(bus.pred_ctr_o), 2);

        // Full flush with dropped update, masked lookup and ignored flush
        update(4'd0, 1'b1); update(4'd0, 1'b1);
        update(4'd15, 1'b1); update(4'd15, 1'b1);
        lookup(4'd0, 2'b11); lookup(4'd15, 2'b11);
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 16; i++) begin
            chk("flush_busy_high", int'(bus.busy_o), 1);
            if (i == 5)       step(1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0, 2'b01);
            else if (i == 10) step(1'b0, 4'd0, 1'b1, 4'd4, 1'b1, 1'b0, 2'd0);
            else if (i == 12) step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 2'd0);
            else              idle();
        end
        chk("flush_busy_low", int'(bus.busy_o), 0);
        for (int i = 0; i < 16; i++) lookup(4'(i), 2'b01);

        // Reset asserted in the middle of a flush
        update(4'd7, 1'b1); update(4'd7, 1'b1);
        update(4'd15, 1'b0);
        lookup(4'd7, 2'b11); lookup(4'd15, 2'b00);
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 2'd0);
        repeat (7) idle();
        chk("midflush_busy_before_reset", int'(bus.busy_o), 1);
        reset = 1'b1;
        #1;
        chk("midflush_reset_busy", int'(bus.busy_o), 0);
        chk("midflush_reset_pred_valid", int'(bus.pred_valid_o), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) lookup(4'(i), 2'b01);

        // New flush accepted after reset; exact busy length
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 2'd0);
        chk("reflush_busy_start", int'(bus.busy_o), 1);
        repeat (15) idle();
        chk("reflush_busy_last", int'(bus.busy_o), 1);
        idle();
        chk("reflush_busy_end", int'(bus.busy_o), 0);

        idle();
        idle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
